// File: rtl/spi_regbank_if.sv
// SPI pin bundle for spi_regbank: the controller drives ncs/sclk/copi,
// the peripheral drives cipo/cipo_oe.
interface spi_regbank_if;
    logic ncs;
    logic sclk;
    logic copi;
    logic cipo;
    logic cipo_oe;

    modport master (output ncs, output sclk, output copi, input cipo, input cipo_oe);
    modport slave  (input ncs, input sclk, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regbank.sv
// Parametrised SPI mode-0 register bank with range-checked writes and frame-error reporting.
// Define SPI_REGBANK_READBACK_EN to build the CIPO read-back path.
module spi_regbank #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_regbank_if.slave               spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int CMD_W   = 1 + ADDR_W;
    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CNT_W   = ($clog2(FRAME_W + 1) > 5) ? $clog2(FRAME_W + 1) : 5;
    localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_W);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_DATA   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_WAIT   = 3'd4
    } state_t;

    function automatic logic addr_impl(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NUM_REGS_W);
    endfunction

    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d, sclk_sync_q, sclk_sync_d, copi_sync_q, copi_sync_d;
    logic                   ncs_hist_q, ncs_hist_d, sclk_hist_q, sclk_hist_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CMD_W-1:0]       cmd_q, cmd_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic                   wr_strobe_q, wr_strobe_d, frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;

    logic ncs_s, sclk_s, copi_s, ncs_fall_s, ncs_rise_s, sclk_rise_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [CMD_W-1:0]  cmd_next_s;
    logic [DATA_W-1:0] data_next_s;

    assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s      = copi_sync_q[SYNC_STAGES-1];
    assign ncs_fall_s  = ncs_hist_q & ~ncs_s;
    assign ncs_rise_s  = ~ncs_hist_q & ncs_s;
    assign sclk_rise_s = ~sclk_hist_q & sclk_s;
    assign cnt_inc_s   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign cmd_next_s  = {cmd_q[CMD_W-2:0], copi_s};
    assign data_next_s = {data_q[DATA_W-2:0], copi_s};

    assign regs_flat = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

`ifdef SPI_REGBANK_READBACK_EN
    logic [DATA_W-1:0] rd_shift_q, rd_shift_d;
    logic              cipo_oe_q, cipo_oe_d;
    logic              sclk_fall_s;

    assign sclk_fall_s = sclk_hist_q & ~sclk_s;
    assign spi.cipo    = rd_shift_q[DATA_W-1];
    assign spi.cipo_oe = cipo_oe_q;

    // Unimplemented addresses read back as zero.
    function automatic logic [DATA_W-1:0] reg_sel(input logic [NUM_REGS*DATA_W-1:0] r,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_REGS; k++) begin
            v = (a == k[ADDR_W-1:0]) ? r[k*DATA_W +: DATA_W] : v;
        end
        return v;
    endfunction
`else
    assign spi.cipo    = 1'b0;
    assign spi.cipo_oe = 1'b0;
`endif

    // Synchronisers, frame FSM, register update and strobes.
    always_comb begin
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
        ncs_hist_d  = ncs_s;
        sclk_hist_d = sclk_s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
`ifdef SPI_REGBANK_READBACK_EN
        rd_shift_d  = rd_shift_q;
        cipo_oe_d   = cipo_oe_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ncs_fall_s) begin
                    state_d = ST_CMD;
                    cnt_d   = {CNT_W{1'b0}};
                    cmd_d   = {CMD_W{1'b0}};
                    data_d  = {DATA_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (ncs_rise_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_rise_s) begin
                    cnt_d = cnt_inc_s;
                    cmd_d = cmd_next_s;
                    if (cnt_inc_s == CMD_LAST) begin
                        state_d = ST_DATA;
`ifdef SPI_REGBANK_READBACK_EN
                        rd_shift_d = cmd_next_s[ADDR_W] ? {DATA_W{1'b0}}
                                                        : reg_sel(regs_q, cmd_next_s[ADDR_W-1:0]);
                        cipo_oe_d  = ~cmd_next_s[ADDR_W];
`endif
                    end else begin
                        state_d = ST_CMD;
                    end
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_DATA: begin
                // A final sclk edge coinciding with ncs rising still completes the frame.
                if (sclk_rise_s) begin
                    cnt_d  = cnt_inc_s;
                    data_d = data_next_s;
                    if (cnt_inc_s == FRAME_LAST) begin
                        state_d = ST_COMMIT;
                    end else if (ncs_rise_s) begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (ncs_rise_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
`ifdef SPI_REGBANK_READBACK_EN
                // The falling edge that closes the last command bit must not shift.
                end else if (sclk_fall_s && (cnt_q != CMD_LAST)) begin
                    rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_COMMIT: begin
                state_d = ST_WAIT;
                if (cmd_q[ADDR_W]) begin
                    if (addr_impl(cmd_q[ADDR_W-1:0])) begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                            regs_d[k*DATA_W +: DATA_W] = (cmd_q[ADDR_W-1:0] == k[ADDR_W-1:0])
                                                         ? data_q : regs_q[k*DATA_W +: DATA_W];
                        end
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = cmd_q[ADDR_W-1:0];
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
`ifdef SPI_REGBANK_READBACK_EN
                    frame_err_d = ~addr_impl(cmd_q[ADDR_W-1:0]);
`else
                    frame_err_d = 1'b0;
`endif
                end
            end
            // Level test: the rising edge may already have been consumed by the final bit.
            ST_WAIT: begin
                state_d = ncs_s ? ST_IDLE : ST_WAIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef SPI_REGBANK_READBACK_EN
        rd_shift_d = (state_d == ST_IDLE) ? {DATA_W{1'b0}} : rd_shift_d;
        cipo_oe_d  = (state_d == ST_IDLE) ? 1'b0 : cipo_oe_d;
`endif
    end

    // State registers; synchronisers reset to an idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync_q  <= {SYNC_STAGES{1'b1}};
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            copi_sync_q <= {SYNC_STAGES{1'b0}};
            ncs_hist_q  <= 1'b1;
            sclk_hist_q <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            cmd_q       <= {CMD_W{1'b0}};
            data_q      <= {DATA_W{1'b0}};
            regs_q      <= {(NUM_REGS*DATA_W){1'b0}};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            frame_err_q <= 1'b0;
`ifdef SPI_REGBANK_READBACK_EN
            rd_shift_q  <= {DATA_W{1'b0}};
            cipo_oe_q   <= 1'b0;
`endif
        end else begin
            ncs_sync_q  <= ncs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_hist_q  <= ncs_hist_d;
            sclk_hist_q <= sclk_hist_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
`ifdef SPI_REGBANK_READBACK_EN
            rd_shift_q  <= rd_shift_d;
            cipo_oe_q   <= cipo_oe_d;
`endif
        end
    end
endmodule

// File: tb/tb_spi_regbank.sv
// Scoreboard bench for spi_regbank: frames push expected strobe/error events,
// a negedge monitor pops and compares whenever wr_strobe or frame_err fires.
module tb_spi_regbank;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 8;
    localparam int RW       = NUM_REGS * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [RW-1:0]     regs_flat;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic              frame_err;

    spi_regbank_if spi_if ();

    spi_regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (spi_if),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              is_err;
        logic [ADDR_W-1:0] addr;
        logic [RW-1:0]     regs;
    } ev_t;

    ev_t               exp_q[$];
    ev_t               mon_e;
    logic [RW-1:0]     model_regs;
    logic [DATA_W-1:0] rx_bits;
    logic              rx_oe_and;
    logic              rx_oe_or;
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ev_t e;
        model_regs[a*DATA_W +: DATA_W] = d;
        e.is_err = 1'b0;
        e.addr   = a;
        e.regs   = model_regs;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        ev_t e;
        e.is_err = 1'b1;
        e.addr   = '0;
        e.regs   = model_regs;
        exp_q.push_back(e);
    endtask

    // Sends nbits MSB first; stops early (abort) after stop_after bits.
    task automatic send(input logic [31:0] bits, input int nbits, input int stop_after);
        rx_bits   = '0;
        rx_oe_and = 1'b1;
        rx_oe_or  = 1'b0;
        spi_if.ncs = 1'b0;
        #40;
        for (int i = 0; i < nbits; i++) begin
            if (i == stop_after) break;
            spi_if.copi = bits[nbits-1-i];
            #40 spi_if.sclk = 1'b1;
            if (i >= 1 + ADDR_W && i < 1 + ADDR_W + DATA_W) begin
                rx_bits   = {rx_bits[DATA_W-2:0], spi_if.cipo};
                rx_oe_and = rx_oe_and & spi_if.cipo_oe;
                rx_oe_or  = rx_oe_or | spi_if.cipo_oe;
            end
            #40 spi_if.sclk = 1'b0;
        end
        #40 spi_if.ncs = 1'b1;
        #120;
    endtask

    always @(negedge clk) begin
        if (rst_n && (wr_strobe || frame_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {62'd0, wr_strobe, frame_err}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", {62'd0, wr_strobe, frame_err}, mon_e.is_err ? 64'd1 : 64'd2);
                if (!mon_e.is_err) check("wr_addr", {57'd0, wr_addr}, {57'd0, mon_e.addr});
                check("regs_at_event", regs_flat, mon_e.regs);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        spi_if.ncs  = 1'b1;
        spi_if.sclk = 1'b0;
        spi_if.copi = 1'b0;
        model_regs  = '0;
        #23;
        check("rst_regs", regs_flat, 64'd0);
        check("rst_wr_strobe", {63'd0, wr_strobe}, 64'd0);
        check("rst_wr_addr", {57'd0, wr_addr}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);
        check("rst_cipo", {63'd0, spi_if.cipo}, 64'd0);
        check("rst_cipo_oe", {63'd0, spi_if.cipo_oe}, 64'd0);
        rst_n = 1'b1;
        #50;

        expect_write(7'd0, 8'h55);
        send(32'h8055, 16, 99);
        check("reg0_after_8055", regs_flat, 64'h0000000000000055);

        expect_write(7'd4, 8'hA5);
        send(32'h84A5, 16, 99);
        expect_write(7'd7, 8'h01);
        send(32'h8701, 16, 99);
        check("regs_after_4_7", regs_flat, 64'h010000A500000055);

        expect_err();
        send(32'h8A33, 16, 99);
        check("regs_after_oor", regs_flat, 64'h010000A500000055);

        expect_err();
        send(32'h83FF, 16, 9);
        check("reg3_after_abort", {56'd0, regs_flat[31:24]}, 64'h00);
        expect_write(7'd3, 8'h12);
        send(32'h8312, 16, 99);
        check("reg3_after_8312", {56'd0, regs_flat[31:24]}, 64'h12);

        expect_write(7'd1, 8'h66);
        send(32'h0008166A, 20, 99);
        check("regs_after_20bit", regs_flat, 64'h010000A512006655);

        send(32'h0400, 16, 99);
`ifdef SPI_REGBANK_READBACK_EN
        check("read_reg4_cipo", {56'd0, rx_bits}, 64'hA5);
        check("read_oe_in_data", {63'd0, rx_oe_and}, 64'd1);
`else
        check("read_cipo_tied", {56'd0, rx_bits}, 64'h00);
        check("read_oe_tied", {63'd0, rx_oe_or}, 64'd0);
`endif
        check("oe_after_ncs", {63'd0, spi_if.cipo_oe}, 64'd0);
        check("regs_after_read", regs_flat, 64'h010000A512006655);

`ifdef SPI_REGBANK_READBACK_EN
        expect_err();
`endif
        send(32'h0A00, 16, 99);
        check("unimpl_read_cipo", {56'd0, rx_bits}, 64'h00);

        #200;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-way through the data phase of a read frame.
        spi_if.ncs = 1'b0;
        #40;
        for (int i = 0; i < 11; i++) begin
            spi_if.copi = (i == 5) ? 1'b1 : 1'b0;
            #40 spi_if.sclk = 1'b1;
            #40 spi_if.sclk = 1'b0;
        end
`ifdef SPI_REGBANK_READBACK_EN
        check("oe_before_reset", {63'd0, spi_if.cipo_oe}, 64'd1);
`endif
        #3 rst_n = 1'b0;
        #1;
        model_regs = '0;
        check("async_rst_regs", regs_flat, 64'd0);
        check("async_rst_cipo", {63'd0, spi_if.cipo}, 64'd0);
        check("async_rst_cipo_oe", {63'd0, spi_if.cipo_oe}, 64'd0);
        check("async_rst_strobes", {62'd0, wr_strobe, frame_err}, 64'd0);
        spi_if.ncs = 1'b1;
        #30 rst_n = 1'b1;
        #50;

        expect_write(7'd2, 8'h3C);
        send(32'h823C, 16, 99);
        check("reg2_after_reset", regs_flat, 64'h00000000003C0000);
        #200;
        check("scoreboard_drained_end", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
